// File: rtl/pipeline_hazard_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : pipeline_pkg
// Purpose  : Shared opcode constants, forwarding-select encodings and the
//            hazard-tracker entry type for the pipeline hazard scheduler.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pipeline_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_ITYPE  = 6'b100011;
  localparam logic [5:0] OP_LOAD   = 6'b101011;
  localparam logic [5:0] OP_STORE  = 6'b000100;
  localparam logic [5:0] OP_BRANCH = 6'b000101;

  localparam logic [1:0] FWD_RF = 2'b00;  // register file
  localparam logic [1:0] FWD_S3 = 2'b01;  // s3 result
  localparam logic [1:0] FWD_S4 = 2'b10;  // s4 writeback data

  // valid is only set for instructions that write a register, so a valid
  // entry always implies a destination write.
  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
  } hz_entry_t;

  localparam hz_entry_t HZ_BUBBLE = '{valid: 1'b0, dest: 5'd0, is_load: 1'b0};

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_hz_opdecode.sv
//------------------------------------------------------------------------------
// Module   : hz_opdecode
// Purpose  : Maps an instruction's opcode and register fields to the set of
//            registers it reads, whether it writes, its destination and
//            whether it is a load.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hz_opdecode
  import pipeline_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rt,
  input  logic [4:0] i_rd,
  output logic       o_uses_rs,
  output logic       o_uses_rt,
  output logic       o_writes,
  output logic [4:0] o_dest,
  output logic       o_is_load
);

  // Opcode table; unknown opcodes read and write nothing.
  always_comb begin
    o_uses_rs = 1'b0;
    o_uses_rt = 1'b0;
    o_writes  = 1'b0;
    o_dest    = i_rd;
    o_is_load = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        o_uses_rs = 1'b1;
        o_uses_rt = 1'b1;
        o_writes  = 1'b1;
        o_dest    = i_rd;
      end
      OP_ITYPE: begin
        o_uses_rs = 1'b1;
        o_writes  = 1'b1;
        o_dest    = i_rt;
      end
      OP_LOAD: begin
        o_uses_rs = 1'b1;
        o_writes  = 1'b1;
        o_dest    = i_rt;
        o_is_load = 1'b1;
      end
      OP_STORE, OP_BRANCH: begin
        o_uses_rs = 1'b1;
        o_uses_rt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module   : pipeline_hazard_ctrl
// Purpose  : Decode-side hazard scheduler. Tracks the destinations of the
//            instructions in s2 and s3, stalls on read-after-write hazards,
//            flushes on a taken branch and registers operand-forwarding
//            selects that travel with each instruction into execute.
// Config   : HAZARD_FWD_EN - enables forwarding (load-use stall only);
//            undefined means stall on any s2/s3 dependency, fwd tied to 00.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             br_taken_s3,
  output logic             stall,
  output logic             flush_s1,
  output logic             flush_s2,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  hz_entry_t        r_e2;
  hz_entry_t        r_e3;
  logic [CNT_W-1:0] r_stall_cnt;

  logic       w_uses_rs;
  logic       w_uses_rt;
  logic       w_writes;
  logic [4:0] w_dest;
  logic       w_is_load;

  hz_opdecode u_opdecode (
    .i_opcode  (id_opcode),
    .i_rs      (id_rs),
    .i_rt      (id_rt),
    .i_rd      (id_rd),
    .o_uses_rs (w_uses_rs),
    .o_uses_rt (w_uses_rt),
    .o_writes  (w_writes),
    .o_dest    (w_dest),
    .o_is_load (w_is_load)
  );

  // Source-versus-entry matches; register 0 is treated like any other.
  logic w_rs_e2, w_rt_e2, w_rs_e3, w_rt_e3;
  assign w_rs_e2 = w_uses_rs && r_e2.valid && (r_e2.dest == id_rs);
  assign w_rt_e2 = w_uses_rt && r_e2.valid && (r_e2.dest == id_rt);
  assign w_rs_e3 = w_uses_rs && r_e3.valid && (r_e3.dest == id_rs);
  assign w_rt_e3 = w_uses_rt && r_e3.valid && (r_e3.dest == id_rt);

  logic w_hazard;
`ifdef HAZARD_FWD_EN
  assign w_hazard = (w_rs_e2 || w_rt_e2) && r_e2.is_load;
`else
  assign w_hazard = w_rs_e2 || w_rt_e2 || w_rs_e3 || w_rt_e3;
`endif

  // A taken branch overrides any stall; reset masks the output only.
  logic w_stall;
  logic w_load_e2;
  assign w_stall   = id_valid && !br_taken_s3 && w_hazard;
  assign w_load_e2 = id_valid && !w_stall && !br_taken_s3;

  assign stall     = w_stall && !reset;
  assign flush_s1  = br_taken_s3 && !reset;
  assign flush_s2  = br_taken_s3 && !reset;
  assign stall_cnt = r_stall_cnt;

  // Tracker shift: E3 takes E2 (bubble on branch), E2 takes decode or bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_e2 <= HZ_BUBBLE;
      r_e3 <= HZ_BUBBLE;
    end else begin
      r_e3 <= br_taken_s3 ? HZ_BUBBLE : r_e2;
      if (w_load_e2) begin
        r_e2.valid   <= w_writes;
        r_e2.dest    <= w_dest;
        r_e2.is_load <= w_is_load;
      end else begin
        r_e2 <= HZ_BUBBLE;
      end
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

`ifdef HAZARD_FWD_EN
  logic [1:0] r_fwd_a;
  logic [1:0] r_fwd_b;
  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;

  // E2 wins over E3; an E2 load match never reaches here because it stalls.
  assign w_sel_a = w_rs_e2 ? FWD_S3 : (w_rs_e3 ? FWD_S4 : FWD_RF);
  assign w_sel_b = w_rt_e2 ? FWD_S3 : (w_rt_e3 ? FWD_S4 : FWD_RF);

  // Forwarding selects load alongside E2 and clear with each bubble.
  always_ff @(posedge clk) begin
    if (reset || !w_load_e2) begin
      r_fwd_a <= FWD_RF;
      r_fwd_b <= FWD_RF;
    end else begin
      r_fwd_a <= w_sel_a;
      r_fwd_b <= w_sel_b;
    end
  end

  assign fwd_a = r_fwd_a;
  assign fwd_b = r_fwd_b;
`else
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;
`endif

  // The s3 load flag is never consulted; this keeps it visibly intentional.
  logic w_unused;
  assign w_unused = r_e3.is_load;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none

module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid;
  logic [5:0]       id_opcode;
  logic [4:0]       id_rs, id_rt, id_rd;
  logic             br_taken_s3;
  logic             stall, flush_s1, flush_s2;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: what sits one and two slots ahead of decode, as
  // destination numbers (-1 = nothing written), plus outputs it expects.
  int m_s2_dst = -1;
  bit m_s2_ld  = 1'b0;
  int m_s3_dst = -1;
  int m_fa     = 0;
  int m_fb     = 0;
  int m_cnt    = 0;
  bit m_stall  = 1'b0;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_opcode   (id_opcode),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rd       (id_rd),
    .br_taken_s3 (br_taken_s3),
    .stall       (stall),
    .flush_s1    (flush_s1),
    .flush_s2    (flush_s2),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Which registers an instruction reads (-1 = none) and which it writes.
  task automatic mdec(input logic [5:0] op, input int rs, input int rt, input int rd,
                      output int r1, output int r2, output int w, output bit ld);
    r1 = -1; r2 = -1; w = -1; ld = 1'b0;
    case (op)
      6'd0:  begin r1 = rs; r2 = rt; w = rd; end
      6'd35: begin r1 = rs; w = rt; end
      6'd43: begin r1 = rs; w = rt; ld = 1'b1; end
      6'd4, 6'd5: begin r1 = rs; r2 = rt; end
      default: ;
    endcase
  endtask

  function automatic int fsel(input int src);
    if (src < 0)         return 0;
    if (src == m_s2_dst) return 1;
    if (src == m_s3_dst) return 2;
    return 0;
  endfunction

  // One clock cycle: drive, check the same-cycle view, advance the model.
  task automatic step(input bit v, input logic [5:0] op, input int rs, input int rt,
                      input int rd, input bit br, input bit rst);
    int r1, r2, w;
    bit ld, hz, st, take;
    @(negedge clk);
    reset = rst; id_valid = v; id_opcode = op;
    id_rs = rs[4:0]; id_rt = rt[4:0]; id_rd = rd[4:0]; br_taken_s3 = br;
    mdec(op, rs, rt, rd, r1, r2, w, ld);
`ifdef HAZARD_FWD_EN
    hz = m_s2_ld && m_s2_dst >= 0 &&
         ((r1 >= 0 && r1 == m_s2_dst) || (r2 >= 0 && r2 == m_s2_dst));
`else
    hz = (r1 >= 0 && (r1 == m_s2_dst || r1 == m_s3_dst)) ||
         (r2 >= 0 && (r2 == m_s2_dst || r2 == m_s3_dst));
`endif
    st = v && !br && hz && !rst;
    m_stall = st;
    #1;
    chk("stall",     int'(stall),     int'(st));
    chk("flush_s1",  int'(flush_s1),  int'(br && !rst));
    chk("flush_s2",  int'(flush_s2),  int'(br && !rst));
    chk("fwd_a",     int'(fwd_a),     m_fa);
    chk("fwd_b",     int'(fwd_b),     m_fb);
    chk("stall_cnt", int'(stall_cnt), m_cnt);
    if (rst) begin
      m_s2_dst = -1; m_s2_ld = 1'b0; m_s3_dst = -1; m_fa = 0; m_fb = 0; m_cnt = 0;
    end else begin
      if (st && m_cnt < CMAX) m_cnt++;
      take = v && !st && !br;
`ifdef HAZARD_FWD_EN
      m_fa = take ? fsel(r1) : 0;
      m_fb = take ? fsel(r2) : 0;
`else
      m_fa = 0; m_fb = 0;
`endif
      m_s3_dst = br ? -1 : m_s2_dst;
      m_s2_dst = take ? w : -1;
      m_s2_ld  = take ? ld : 1'b0;
    end
  endtask

  // Present an instruction until it leaves decode, bounded.
  task automatic issue(input logic [5:0] op, input int rs, input int rt, input int rd);
    int k;
    k = 0;
    do begin
      step(1'b1, op, rs, rt, rd, 1'b0, 1'b0);
      k++;
    end while (m_stall && k < 8);
    chk("issue_bound", int'(m_stall), 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 6'd63, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 6'd63, 0, 0, 0, 1'b0, 1'b1);
    step(1'b0, 6'd63, 0, 0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_opcode = 6'd63;
    id_rs = '0; id_rt = '0; id_rd = '0; br_taken_s3 = 1'b0;

    // Reset state
    do_reset();
    idle(1);
    chk("reset_cnt_zero", int'(stall_cnt), 0);

    // Back-to-back dependency on r5
    issue(6'd0, 1, 2, 5);
    issue(6'd0, 5, 6, 7);
    idle(2);
`ifndef HAZARD_FWD_EN
    chk("b2b_cnt", int'(stall_cnt), 2);
`endif

    // Load then use of r7 via rt
    do_reset();
    issue(6'd43, 1, 7, 0);
    issue(6'd0, 2, 7, 4);
    idle(2);

    // Distance two: I-type r3, unrelated, store reads r3
    do_reset();
    issue(6'd35, 0, 3, 0);
    issue(6'd63, 8, 8, 8);
    issue(6'd4, 3, 1, 0);
    idle(2);

    // Taken branch during a load-use stall
    do_reset();
    issue(6'd43, 1, 7, 0);
    step(1'b1, 6'd0, 2, 7, 4, 1'b1, 1'b0);
    idle(3);

    // Reset asserted mid-stall
    do_reset();
    issue(6'd43, 0, 9, 0);
    step(1'b1, 6'd0, 9, 9, 1, 1'b0, 1'b1);
    idle(2);
    chk("post_reset_cnt", int'(stall_cnt), 0);

    // Counter saturation
    do_reset();
    for (int i = 0; i < 20; i++) begin
      issue(6'd43, 1, 10, 0);
      issue(6'd0, 10, 10, 2);
    end
    idle(1);
    chk("sat_cnt", int'(stall_cnt), CMAX);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      case ($urandom_range(0, 5))
        0: op = 6'd0;
        1: op = 6'd35;
        2: op = 6'd43;
        3: op = 6'd4;
        4: op = 6'd5;
        default: op = 6'd63;
      endcase
      step(($urandom_range(0, 9) != 0), op,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
